// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: map-writer FSM states, default conv2
// geometry and the width helpers used to size raster counters and addresses.
package cnn_pkg;

    localparam int MAP_DIM_DEF = 8;
    localparam int DATA_W_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } wr_state_e;

    // Width of an address covering a dim x dim map (at least 1 bit).
    function automatic int addr_width(input int dim);
        return (dim * dim > 1) ? $clog2(dim * dim) : 1;
    endfunction

    // Width of a row or column index for a dim-wide map (at least 1 bit).
    function automatic int cnt_width(input int dim);
        return (dim > 1) ? $clog2(dim) : 1;
    endfunction

endpackage

// File: rtl/raster_counter.sv
// Row/column raster counter for a DIM x DIM map. The column advances on each
// enable and wraps into the row; clear has priority over enable. last_o flags
// the final position so the owner can detect map completion.
module raster_counter
    import cnn_pkg::*;
#(
    parameter int DIM   = MAP_DIM_DEF,
    parameter int CNT_W = cnt_width(DIM)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] row_o,
    output logic [CNT_W-1:0] col_o,
    output logic             last_o
);

    logic [CNT_W-1:0] row_q, row_d;
    logic [CNT_W-1:0] col_q, col_d;
    logic             col_wrap;
    logic             row_wrap;

    assign col_wrap = (col_q == CNT_W'(DIM - 1));
    assign row_wrap = (row_q == CNT_W'(DIM - 1));

    // Next raster position: clear, advance with column-to-row carry, or hold.
    always_comb begin
        // NOTE: defaults first so every path assigns; no latch is inferred.
        row_d = row_q;
        col_d = col_q;
        if (clr_i) begin
            row_d = '0;
            col_d = '0;
        end else if (en_i) begin
            if (col_wrap) begin
                col_d = '0;
                row_d = row_wrap ? '0 : row_q + CNT_W'(1);
            end else begin
                col_d = col_q + CNT_W'(1);
            end
        end
    end

    // Position registers.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (reset) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o  = row_q;
    assign col_o  = col_q;
    assign last_o = row_wrap & col_wrap;

endmodule

// File: rtl/conv2_mem_write.sv
// Conv2 output map writer. After a start pulse it accepts MAP_DIM*MAP_DIM
// samples in raster order and emits one registered memory write per accepted
// sample, one cycle later. done then enables the pooling-window reader.
// Samples offered while not armed are dropped and flagged on the sticky
// overrun output.
// Build option: define CONV2_WR_RELU_EN to clamp negative samples to zero
// before storage; handshake and latency are unchanged.
module conv2_mem_write
    import cnn_pkg::*;
#(
    parameter int MAP_DIM = MAP_DIM_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             in_valid,
    input  logic [DATA_W-1:0]                in_data,
    output logic                             in_ready,
    output logic                             wr_en,
    output logic [addr_width(MAP_DIM)-1:0]   wr_addr,
    output logic [DATA_W-1:0]                wr_data,
    output logic                             busy,
    output logic                             done,
    output logic                             overrun
);

    localparam int ADDR_W = addr_width(MAP_DIM);
    localparam int CNT_W  = cnt_width(MAP_DIM);

    wr_state_e         state_q;
    logic              in_ready_q;
    logic              busy_q;
    logic              done_q;
    logic              overrun_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic              accept;
    logic              arm;
    logic              last;
    logic [CNT_W-1:0]  row;
    logic [CNT_W-1:0]  col;

    // in_ready is only ever high in WRITE, so accept implies WRITE.
    assign accept = in_valid & in_ready_q;
    // start is honoured only outside WRITE; it also rewinds the raster.
    assign arm    = start & (state_q != WRITE);

    raster_counter #(
        .DIM   (MAP_DIM),
        .CNT_W (CNT_W)
    ) u_raster (
        .clk    (clk),
        .reset  (reset),
        .en_i   (accept),
        .clr_i  (arm),
        .row_o  (row),
        .col_o  (col),
        .last_o (last)
    );

    assign wr_addr_d = ADDR_W'(row) * ADDR_W'(MAP_DIM) + ADDR_W'(col);

`ifdef CONV2_WR_RELU_EN
    assign wr_data_d = in_data[DATA_W-1] ? '0 : in_data;
`else
    assign wr_data_d = in_data;
`endif

    // Control FSM with registered handshake, write and status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            wr_en_q <= 1'b0;
            // done rises the cycle after entering DONE and holds until start.
            done_q  <= (state_q == DONE) && !start;

            // A sample offered while not armed wins over a coincident start.
            if (state_q != WRITE) begin
                if (in_valid) begin
                    overrun_q <= 1'b1;
                end else if (start) begin
                    overrun_q <= 1'b0;
                end
            end

            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q    <= WRITE;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                WRITE: begin
                    if (accept) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= wr_addr_d;
                        wr_data_q <= wr_data_d;
                        if (last) begin
                            state_q    <= DONE;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overrun  = overrun_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_conv2_mem_write.sv
// Testbench for conv2_mem_write at default geometry (8x8, 16-bit samples).
// Expected writes are queued when a sample is driven into an armed model and
// compared when wr_en appears; status outputs are tracked by a cycle model.
module tb_conv2_mem_write;

    localparam int MAP_DIM = 8;
    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 6;
    localparam int N       = MAP_DIM * MAP_DIM;

    localparam int M_IDLE  = 0;
    localparam int M_WRITE = 1;
    localparam int M_DONE  = 2;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              done;
    logic              overrun;

    int  vectors     = 0;
    int  miscompares = 0;
    wr_t sb[$];

    int  m_state = M_IDLE;
    int  m_addr  = 0;
    bit  m_done  = 1'b0;
    bit  m_ovr   = 1'b0;

    always #5 clk = ~clk;

    conv2_mem_write #(
        .MAP_DIM (MAP_DIM),
        .DATA_W  (DATA_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .overrun  (overrun)
    );

    function automatic logic [DATA_W-1:0] ref_data(input logic [DATA_W-1:0] d);
`ifdef CONV2_WR_RELU_EN
        return d[DATA_W-1] ? '0 : d;
`else
        return d;
`endif
    endfunction

    function automatic void model_reset();
        m_state = M_IDLE;
        m_addr  = 0;
        m_done  = 1'b0;
        m_ovr   = 1'b0;
        sb.delete();
    endfunction

    // Advance one clock: update the model with the inputs as driven, then
    // sample the DUT 1 time unit after the rising edge.
    task automatic tick();
        bit  acc;
        bit  n_done;
        bit  exp_act;
        wr_t exp;
        acc    = in_valid && (m_state == M_WRITE);
        n_done = (m_state == M_DONE) && !start;
        if (m_state != M_WRITE) begin
            if (in_valid)   m_ovr = 1'b1;
            else if (start) m_ovr = 1'b0;
        end
        if (acc) begin
            sb.push_back(wr_t'{addr: ADDR_W'(m_addr), data: ref_data(in_data)});
            if (m_addr == N - 1) m_state = M_DONE;
            m_addr++;
        end else if (m_state != M_WRITE && start) begin
            m_state = M_WRITE;
            m_addr  = 0;
        end
        m_done = n_done;

        @(posedge clk);
        #1;

        if (wr_en) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write: wr_addr=%0d wr_data=%h, required no write", wr_addr, wr_data);
            end else begin
                exp = sb.pop_front();
                if ({wr_addr, wr_data} !== {exp.addr, exp.data}) begin
                    miscompares++;
                    $display("FAIL write: wr_addr=%0d wr_data=%h, required wr_addr=%0d wr_data=%h",
                             wr_addr, wr_data, exp.addr, exp.data);
                end
            end
        end else if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            exp = sb.pop_front();
            $display("FAIL missing_write: wr_en=0, required write addr=%0d data=%h", exp.addr, exp.data);
        end

        exp_act = (m_state == M_WRITE);
        vectors++;
        if ({in_ready, busy, done, overrun} !== {exp_act, exp_act, m_done, m_ovr}) begin
            miscompares++;
            $display("FAIL status: in_ready/busy/done/overrun=%b%b%b%b, required %b%b%b%b",
                     in_ready, busy, done, overrun, exp_act, exp_act, m_done, m_ovr);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [DATA_W-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({wr_en, wr_addr, wr_data} !== '0) begin
            miscompares++;
            $display("FAIL reset_write_port: wr_en=%b wr_addr=%0d wr_data=%h, required all zero", wr_en, wr_addr, wr_data);
        end
        vectors++;
        if ({in_ready, busy, done, overrun} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_status: in_ready/busy/done/overrun=%b%b%b%b, required 0000", in_ready, busy, done, overrun);
        end
        #2 reset = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        pulse_start();
        for (int k = 0; k < N; k++) send(DATA_W'(k));
        vectors++;
        if ({wr_en, wr_addr, wr_data} !== {1'b1, 6'd63, 16'd63}) begin
            miscompares++;
            $display("FAIL b2b_last_write: wr_en=%b wr_addr=%0d wr_data=%0d, required 1 63 63", wr_en, wr_addr, wr_data);
        end
        vectors++;
        if ({in_ready, done} !== 2'b00) begin
            miscompares++;
            $display("FAIL b2b_at_last: in_ready=%b done=%b, required 0 0", in_ready, done);
        end
        tick();
        vectors++;
        if ({done, in_ready, wr_en} !== 3'b100) begin
            miscompares++;
            $display("FAIL b2b_done: done=%b in_ready=%b wr_en=%b, required 1 0 0", done, in_ready, wr_en);
        end
    endtask

    task automatic test_gaps();
        pulse_start();
        for (int k = 0; k < N; k++) begin
            send(DATA_W'(200 + k));
            vectors++;
            if ({wr_en, wr_addr} !== {1'b1, ADDR_W'(k)}) begin
                miscompares++;
                $display("FAIL gap_addr: wr_en=%b wr_addr=%0d, required 1 %0d", wr_en, wr_addr, k);
            end
            in_data = DATA_W'($urandom);
            tick();
            vectors++;
            if (wr_en !== 1'b0) begin
                miscompares++;
                $display("FAIL gap_idle: wr_en=%b, required 0 in gap after %0d", wr_en, k);
            end
        end
        vectors++;
        if ({done, busy} !== 2'b10) begin
            miscompares++;
            $display("FAIL gap_done: done=%b busy=%b after 128 cycles, required 1 0", done, busy);
        end
    endtask

    task automatic test_relu();
        logic [DATA_W-1:0] exp_neg;
`ifdef CONV2_WR_RELU_EN
        exp_neg = 16'h0000;
`else
        exp_neg = 16'hFFF0;
`endif
        pulse_start();
        send(16'hFFF0);
        vectors++;
        if (wr_data !== exp_neg) begin
            miscompares++;
            $display("FAIL relu_neg: wr_data=%h, required %h", wr_data, exp_neg);
        end
        send(16'h0005);
        vectors++;
        if (wr_data !== 16'h0005) begin
            miscompares++;
            $display("FAIL relu_pos: wr_data=%h, required 0005", wr_data);
        end
        for (int k = 2; k < N; k++) send(DATA_W'($urandom));
        tick();
    endtask

    task automatic test_reset_mid();
        pulse_start();
        for (int k = 0; k < 30; k++) send(DATA_W'(1000 + k));
        #2 reset = 1'b1;
        #1;
        model_reset();
        vectors++;
        if ({wr_en, wr_addr, wr_data, in_ready, busy, done, overrun} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid: wr_en=%b wr_addr=%0d wr_data=%h rdy/busy/done/ovr=%b%b%b%b, required all zero",
                     wr_en, wr_addr, wr_data, in_ready, busy, done, overrun);
        end
        @(posedge clk);
        #3 reset = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'h1234;
        repeat (3) tick();
        in_valid = 1'b0;
        pulse_start();
        send(16'h00AA);
        vectors++;
        if ({wr_en, wr_addr} !== {1'b1, 6'd0}) begin
            miscompares++;
            $display("FAIL restart_addr: wr_en=%b wr_addr=%0d, required 1 0", wr_en, wr_addr);
        end
        for (int k = 1; k < N; k++) send(DATA_W'($urandom));
        tick();
    endtask

    task automatic test_overrun();
        in_valid = 1'b1;
        in_data  = 16'h0BAD;
        tick();
        in_valid = 1'b0;
        vectors++;
        if ({overrun, wr_en, done} !== 3'b101) begin
            miscompares++;
            $display("FAIL ovr_done: overrun=%b wr_en=%b done=%b, required 1 0 1", overrun, wr_en, done);
        end
        tick();
        vectors++;
        if (overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL ovr_sticky: overrun=%b, required 1", overrun);
        end
        pulse_start();
        vectors++;
        if ({overrun, done, busy} !== 3'b001) begin
            miscompares++;
            $display("FAIL ovr_clear: overrun=%b done=%b busy=%b, required 0 0 1", overrun, done, busy);
        end
        for (int k = 0; k < N; k++) send(DATA_W'($urandom));
        tick();
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h7777;
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        vectors++;
        if ({overrun, busy, wr_en} !== 3'b110) begin
            miscompares++;
            $display("FAIL ovr_start_valid: overrun=%b busy=%b wr_en=%b, required 1 1 0", overrun, busy, wr_en);
        end
        for (int k = 0; k < N; k++) send(DATA_W'($urandom));
        tick();
    endtask

    task automatic test_start_ignored();
        pulse_start();
        for (int k = 0; k < 9; k++) send(DATA_W'(300 + k));
        start = 1'b1;
        send(DATA_W'(309));
        start = 1'b0;
        vectors++;
        if ({busy, wr_addr} !== {1'b1, 6'd9}) begin
            miscompares++;
            $display("FAIL start_in_write: busy=%b wr_addr=%0d, required 1 9", busy, wr_addr);
        end
        send(DATA_W'(310));
        vectors++;
        if ({wr_en, wr_addr, wr_data} !== {1'b1, 6'd10, 16'd310}) begin
            miscompares++;
            $display("FAIL eleventh_accept: wr_en=%b wr_addr=%0d wr_data=%0d, required 1 10 310", wr_en, wr_addr, wr_data);
        end
        for (int k = 11; k < N; k++) send(DATA_W'(300 + k));
        tick();
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL start_ign_done: done=%b, required 1", done);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gaps();
        test_relu();
        test_reset_mid();
        test_overrun();
        test_start_ignored();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/conv2_mem_write.md
CONV2_MEM_WRITE -- requirements
Module: conv2_mem_write

Interface
REQ-001 SHALL provide parameter MAP_DIM, default 8, giving the conv2 output map side (MAP_DIM x MAP_DIM entries).
REQ-002 SHALL provide parameter DATA_W, default 16, giving the signed conv2 output sample width.
REQ-003 SHALL provide port clk, input, 1 bit: clock, rising-edge active.
REQ-004 SHALL provide port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL provide port start, input, 1 bit: single-cycle pulse that arms a map write.
REQ-006 SHALL provide port in_valid, input, 1 bit: conv2 sample valid.
REQ-007 SHALL provide port in_data, input, DATA_W bits: conv2 sample, signed.
REQ-008 SHALL provide port in_ready, output, 1 bit: block accepts a sample this cycle.
REQ-009 SHALL provide port wr_en, output, 1 bit: memory write strobe.
REQ-010 SHALL provide port wr_addr, output, clog2(MAP_DIM*MAP_DIM) bits (6 at default): memory write address.
REQ-011 SHALL provide port wr_data, output, DATA_W bits: memory write data.
REQ-012 SHALL provide port busy, output, 1 bit: high in WRITE.
REQ-013 SHALL provide port done, output, 1 bit: map fully written; enables the pooling-window reader.
REQ-014 SHALL provide port overrun, output, 1 bit: sticky flag for a sample offered while not armed.

Function
REQ-015 SHALL implement the FSM states IDLE, WRITE and DONE.
REQ-016 IDLE: in_ready=0; start -> WRITE with row and col counters cleared.
REQ-017 WRITE: in_ready=1; accept = in_valid & in_ready.
REQ-018 Each accept SHALL produce, on the next rising edge, registered wr_en=1, wr_addr=row*MAP_DIM+col, wr_data=sample (latency 1); without an accept, wr_en=0.
REQ-019 The write order SHALL be raster order: col increments per accept; at col=MAP_DIM-1, col wraps to 0 and row increments.
REQ-020 Gaps in in_valid SHALL stall the counters with no address skipped or repeated.
REQ-021 The accept at row=col=MAP_DIM-1 (64th at default) SHALL move the FSM to DONE; in_ready drops in the same cycle as the FSM enters DONE.
REQ-022 done SHALL go high the cycle after the final wr_en pulse and hold until start or reset.
REQ-023 DONE: start -> WRITE, counters cleared, done cleared.
REQ-024 start in WRITE SHALL be ignored.
REQ-025 in_valid=1 while in IDLE or DONE SHALL set overrun; the sample is dropped and no write occurs.
REQ-026 overrun SHALL be cleared only by reset or start.
REQ-027 start coincident with in_valid in IDLE or DONE SHALL still set overrun; the sample is not written.
REQ-028 wr_addr SHALL never exceed MAP_DIM*MAP_DIM-1.

Reset
REQ-029 Reset SHALL force: state=IDLE, row=col=0, wr_en=0, wr_addr=0, wr_data=0, in_ready=0, busy=0, done=0, overrun=0.
REQ-030 Reset mid-WRITE SHALL abandon the partial map; no further wr_en occurs until the next start.

Configuration
REQ-031 With macro CONV2_WR_RELU_EN defined, wr_data SHALL be 0 for negative in_data and in_data otherwise (ReLU fused before storage).
REQ-032 Without CONV2_WR_RELU_EN, wr_data SHALL equal in_data unmodified; latency and handshake are identical in both builds.

Structure
REQ-033 A shared package cnn_pkg SHALL hold the state enum type, the default MAP_DIM/DATA_W constants and the address-width function.
REQ-034 The row/col raster counter SHALL be a sub-module raster_counter (enable, clear, wrap at MAP_DIM, last flag), reusable by the memory readers.

Verification
REQ-035 Test 1: start, then 64 back-to-back samples with values 0..63 -> wr_addr k receives data k; done=1 one cycle after the write to address 63; in_ready=0 afterwards.
REQ-036 Test 2: in_valid toggling 1/0 every cycle -> same 64 writes in raster order with no skipped or repeated address; done after 128 cycles.
REQ-037 Test 3: in_data=0xFFF0, then 0x0005 -> with the macro, wr_data=0x0000 then 0x0005; without the macro, wr_data=0xFFF0 then 0x0005.
REQ-038 Test 4: reset asserted after the 30th accept -> all outputs return to reset values; new start and 64 samples -> writes restart at address 0.
REQ-039 Test 5: in_valid asserted in DONE -> overrun=1, no wr_en; next start -> overrun=0, done=0, busy=1.
REQ-040 Test 6: start pulsed at the 10th accept of a WRITE pass -> ignored; the 11th accept writes address 10.
